// File: rtl/bfu_array_pipe.sv
// bfu_array_pipe: LANES modular butterfly lanes (NTT/INTT/PWM/SCALE) in a PIPE-deep
// elastic pipeline; the whole pipe freezes when the output beat is not accepted.
module bfu_array_pipe #(
  parameter int LANES = 4,
  parameter int W     = 12,
  parameter int Q     = 3329,
  parameter int PIPE  = 4,
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [LANES*W-1:0]   in_x,
  input  logic [LANES*W-1:0]   in_y,
  input  logic [LANES*W-1:0]   in_coef,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_x,
  output logic [LANES*W-1:0]   out_y,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam logic [W:0]     L_Q     = (W+1)'(Q);
  localparam logic [2*W-1:0] L_Q2    = (2*W)'(Q);
  localparam logic [1:0]     M_NTT   = 2'd0;
  localparam logic [1:0]     M_INTT  = 2'd1;
  localparam logic [1:0]     M_PWM   = 2'd2;
  localparam logic [1:0]     M_SCALE = 2'd3;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= L_Q) s = s - L_Q;
    else          s = s;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + L_Q - {1'b0, b};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % L_Q2;
    return p[W-1:0];
  endfunction

  // First compute stage: all products that depend only on the raw operands.
  // For PWM, ev selects the even (a0*b0, a1*b1) or odd (a0*b1, a1*b0) half of the pair.
  function automatic logic [2*W-1:0] lane_s2(input logic [1:0] m, input logic [W-1:0] x,
                                             input logic [W-1:0] y, input logic [W-1:0] c,
                                             input logic [W-1:0] xp, input logic [W-1:0] yp,
                                             input logic ev);
    logic [W-1:0] a;
    logic [W-1:0] b;
    case (m)
      M_NTT:   begin a = x;             b = mod_mul(c, y); end
      M_INTT:  begin a = mod_add(x, y); b = mod_mul(mod_sub(x, y), c); end
      M_PWM: begin
        if (ev) begin a = mod_mul(x, y);  b = mod_mul(xp, yp); end
        else    begin a = mod_mul(xp, y); b = mod_mul(x, yp);  end
      end
      M_SCALE: begin a = mod_mul(x, c); b = mod_mul(y, c); end
      default: begin a = {W{1'b0}};     b = {W{1'b0}}; end
    endcase
    return {a, b};
  endfunction

  function automatic logic [2*W-1:0] lane_s3(input logic [1:0] m, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] z,
                                             input logic ev);
    logic [2*W-1:0] r;
    case (m)
      M_NTT: r = {mod_add(a, b), mod_sub(a, b)};
      M_PWM: begin
        if (ev) r = {mod_add(a, mod_mul(b, z)), {W{1'b0}}};
        else    r = {mod_add(a, b), {W{1'b0}}};
      end
      default: r = {a, b};
    endcase
    return r;
  endfunction

  logic [PIPE:1]        r_v;
  logic [1:0]           r_s1_mode, r_s2_mode;
  logic [LANES*W-1:0]   r_s1_x, r_s1_y, r_s1_c;
  logic [LANES*W-1:0]   r_s2_a, r_s2_b, r_s2_c;
  logic [TAG_W-1:0]     r_tag [1:PIPE];
  logic [LANES*W-1:0]   r_ox  [3:PIPE];
  logic [LANES*W-1:0]   r_oy  [3:PIPE];
  logic                 w_adv;
  logic [LANES*W-1:0]   w_s2_a, w_s2_b, w_s3_x, w_s3_y;

  assign w_adv     = !(r_v[PIPE] && !out_ready);
  assign in_ready  = w_adv;
  assign out_valid = r_v[PIPE];
  assign out_x     = r_ox[PIPE];
  assign out_y     = r_oy[PIPE];
  assign out_tag   = r_tag[PIPE];
  assign busy      = |r_v;

  // Per-lane products from stage-1 operands; k^1 is the PWM pair partner.
  always_comb begin
    w_s2_a = '0;
    w_s2_b = '0;
    for (int k = 0; k < LANES; k++) begin
      {w_s2_a[k*W +: W], w_s2_b[k*W +: W]} =
        lane_s2(r_s1_mode, r_s1_x[k*W +: W], r_s1_y[k*W +: W], r_s1_c[k*W +: W],
                r_s1_x[(k^1)*W +: W], r_s1_y[(k^1)*W +: W], (k & 1) == 0);
    end
  end

  // Per-lane final combine from stage-2 products.
  always_comb begin
    w_s3_x = '0;
    w_s3_y = '0;
    for (int k = 0; k < LANES; k++) begin
      {w_s3_x[k*W +: W], w_s3_y[k*W +: W]} =
        lane_s3(r_s2_mode, r_s2_a[k*W +: W], r_s2_b[k*W +: W], r_s2_c[k*W +: W], (k & 1) == 0);
    end
  end

  // Stage-valid chain: shifts on advance, frozen on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else if (w_adv) begin
      r_v[1] <= in_valid;
      for (int s = 2; s <= PIPE; s++) r_v[s] <= r_v[s-1];
    end
  end

  // Data stages load only when a valid beat moves in, so idle outputs hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_mode <= 2'd0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
      r_s1_c    <= '0;
      r_s2_mode <= 2'd0;
      r_s2_a    <= '0;
      r_s2_b    <= '0;
      r_s2_c    <= '0;
      for (int s = 1; s <= PIPE; s++) r_tag[s] <= '0;
      for (int s = 3; s <= PIPE; s++) begin
        r_ox[s] <= '0;
        r_oy[s] <= '0;
      end
    end else if (w_adv) begin
      if (in_valid) begin
        r_s1_mode <= in_mode;
        r_s1_x    <= in_x;
        r_s1_y    <= in_y;
        r_s1_c    <= in_coef;
        r_tag[1]  <= in_tag;
      end
      if (r_v[1]) begin
        r_s2_mode <= r_s1_mode;
        r_s2_a    <= w_s2_a;
        r_s2_b    <= w_s2_b;
        r_s2_c    <= r_s1_c;
      end
      if (r_v[2]) begin
        r_ox[3] <= w_s3_x;
        r_oy[3] <= w_s3_y;
      end
      for (int s = 2; s <= PIPE; s++) begin
        if (r_v[s-1]) r_tag[s] <= r_tag[s-1];
      end
      for (int s = 4; s <= PIPE; s++) begin
        if (r_v[s-1]) begin
          r_ox[s] <= r_ox[s-1];
          r_oy[s] <= r_oy[s-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_bfu_array_pipe.sv
// Randomised self-checking bench for bfu_array_pipe with a plain-arithmetic reference
// model, an in-order expectation queue and a per-cycle output monitor.
module tb_bfu_array_pipe;

  localparam int LANES = 4;
  localparam int W     = 12;
  localparam int Q     = 3329;
  localparam int PIPE  = 4;
  localparam int TAG_W = 8;
  localparam int DW    = LANES*W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_mode = 2'd0;
  logic [DW-1:0]     in_x = '0, in_y = '0, in_coef = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     out_x, out_y;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;

  bfu_array_pipe #(.LANES(LANES), .W(W), .Q(Q), .PIPE(PIPE), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_coef(in_coef), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each lane's result straight from the mode's modular formula.
  function automatic void model(input logic [1:0] m, input logic [DW-1:0] px,
                                input logic [DW-1:0] py, input logic [DW-1:0] pc,
                                output logic [DW-1:0] ox, output logic [DW-1:0] oy);
    longint x[LANES], y[LANES], c[LANES], rx, ry;
    for (int k = 0; k < LANES; k++) begin
      x[k] = longint'(px[k*W +: W]);
      y[k] = longint'(py[k*W +: W]);
      c[k] = longint'(pc[k*W +: W]);
    end
    ox = '0;
    oy = '0;
    for (int k = 0; k < LANES; k++) begin
      case (m)
        2'd0: begin rx = (x[k] + c[k]*y[k]) % Q; ry = (((x[k] - c[k]*y[k]) % Q) + Q) % Q; end
        2'd1: begin rx = (x[k] + y[k]) % Q;      ry = ((((x[k] - y[k]) % Q) + Q) % Q) * c[k] % Q; end
        2'd2: begin
          if (k % 2 == 0) rx = (x[k]*y[k] + x[k+1]*y[k+1]*c[k]) % Q;
          else            rx = (x[k-1]*y[k] + x[k]*y[k-1]) % Q;
          ry = 0;
        end
        default: begin rx = (x[k]*c[k]) % Q; ry = (y[k]*c[k]) % Q; end
      endcase
      ox[k*W +: W] = rx[W-1:0];
      oy[k*W +: W] = ry[W-1:0];
    end
  endfunction

  function automatic logic [DW-1:0] rep(input int v);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*W +: W] = W'($urandom_range(0, Q-1));
    return r;
  endfunction

  typedef struct {
    logic [DW-1:0]    ex;
    logic [DW-1:0]    ey;
    logic [TAG_W-1:0] tg;
    int               acc;
    int               stl;
  } exp_t;

  exp_t          q[$];
  int            cyc = 0;
  int            stall_cnt = 0;
  bit            front_seen = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_x = '0, prev_y = '0;
  logic [TAG_W-1:0] prev_tag = '0;
  int            rdy_mode = 0;

  // Output-ready pattern: 0 = always ready, 1 = held low, 2 = random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: inputs are stable here, so this sees exactly the transfers of the next edge.
  always @(negedge clk) begin
    exp_t e, n;
    cyc++;
    if (!rst_n) begin
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      q.delete();
      front_seen = 0;
      prev_stall = 0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      check("busy", 64'(busy), 64'(q.size() != 0));
      if (prev_stall) check("stall_valid_held", 64'(out_valid), 64'd1);
      if (prev_stall || !out_valid) begin
        check("hold_x", 64'(out_x), 64'(prev_x));
        check("hold_y", 64'(out_y), 64'(prev_y));
        check("hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_beat", 64'd1, 64'd0);
        end else begin
          e = q[0];
          check("out_x", 64'(out_x), 64'(e.ex));
          check("out_y", 64'(out_y), 64'(e.ey));
          check("out_tag", 64'(out_tag), 64'(e.tg));
          if (!front_seen) check("latency", 64'(cyc), 64'(e.acc + PIPE + (stall_cnt - e.stl)));
          front_seen = 1;
          if (out_ready) begin
            void'(q.pop_front());
            front_seen = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        model(in_mode, in_x, in_y, in_coef, n.ex, n.ey);
        n.tg  = in_tag;
        n.acc = cyc;
        n.stl = stall_cnt;
        q.push_back(n);
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) stall_cnt++;
    end
    prev_x   = out_x;
    prev_y   = out_y;
    prev_tag = out_tag;
  end

  task automatic send_beat(input logic [1:0] m, input logic [DW-1:0] x, input logic [DW-1:0] y,
                           input logic [DW-1:0] c, input logic [TAG_W-1:0] tg);
    bit acc;
    bit done;
    int n;
    in_valid = 1'b1;
    in_mode  = m;
    in_x     = x;
    in_y     = y;
    in_coef  = c;
    in_tag   = tg;
    done = 0;
    n = 0;
    while (!done) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1;
      else begin
        n++;
        if (n > 100) begin
          check("accept_timeout", 64'd0, 64'd1);
          done = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] mx, my, vx, vy, vc;
    int n;

    // Pin the model against hand-computed values.
    model(2'd0, rep(1), rep(2), rep(3), mx, my);
    check("pin_ntt_x", 64'(mx[W-1:0]), 64'd7);
    check("pin_ntt_y", 64'(my[W-1:0]), 64'd3324);
    model(2'd1, rep(5), rep(7), rep(2), mx, my);
    check("pin_intt_x", 64'(mx[W-1:0]), 64'd12);
    check("pin_intt_y", 64'(my[W-1:0]), 64'd3325);
    model(2'd0, rep(3328), rep(3328), rep(1), mx, my);
    check("pin_ntt_bnd_x", 64'(mx[W-1:0]), 64'd3327);
    check("pin_ntt_bnd_y", 64'(my[W-1:0]), 64'd0);
    vx = rep(0); vy = rep(0); vc = rep(0);
    vx[0 +: W] = 12'd1; vx[W +: W] = 12'd2;
    vy[0 +: W] = 12'd3; vy[W +: W] = 12'd4;
    vc[0 +: W] = 12'd17; vc[W +: W] = 12'd99;
    model(2'd2, vx, vy, vc, mx, my);
    check("pin_pwm_x0", 64'(mx[W-1:0]), 64'd139);
    check("pin_pwm_x1", 64'(mx[W +: W]), 64'd10);
    check("pin_pwm_y", 64'(my[2*W-1:0]), 64'd0);
    model(2'd3, rep(3328), rep(2), rep(2), mx, my);
    check("pin_scale_x", 64'(mx[W-1:0]), 64'd3327);
    check("pin_scale_y", 64'(my[W-1:0]), 64'd4);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_x", 64'(out_x), 64'd0);
    check("reset_out_y", 64'(out_y), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    idle(2);

    // Directed NTT beat with literal checks on the DUT itself.
    send_beat(2'd0, rep(1), rep(2), rep(3), 8'hA5);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("lit_ntt_x", 64'(out_x), 64'(rep(7)));
    check("lit_ntt_y", 64'(out_y), 64'(rep(3324)));
    check("lit_ntt_tag", 64'(out_tag), 64'hA5);
    @(posedge clk);
    #1;

    send_beat(2'd1, rep(5), rep(7), rep(2), 8'h11);
    send_beat(2'd0, rep(3328), rep(3328), rep(1), 8'h12);
    send_beat(2'd2, vx, vy, vc, 8'h13);
    send_beat(2'd3, rep(3328), rep(2), rep(2), 8'h14);
    idle(PIPE + 2);

    // Interleaved modes back-to-back, tags 0..3.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] md;
      case (i)
        0:       md = 2'd0;
        1:       md = 2'd2;
        2:       md = 2'd3;
        default: md = 2'd1;
      endcase
      send_beat(md, rnd_vec(), rnd_vec(), rnd_vec(), TAG_W'(i));
    end
    idle(PIPE + 2);

    // 8 back-to-back beats with a 5-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(), rnd_vec(), TAG_W'(8'h20 + i));
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        rdy_mode = 1;
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    idle(PIPE + 4);

    // Reset with 3 beats in flight.
    for (int i = 0; i < 3; i++) send_beat(2'd0, rnd_vec(), rnd_vec(), rnd_vec(), TAG_W'(8'h40 + i));
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    send_beat(2'd3, rnd_vec(), rnd_vec(), rnd_vec(), 8'h55);
    idle(PIPE + 3);

    // Randomised traffic with random backpressure and input gaps.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send_beat(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(), rnd_vec(), TAG_W'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    n = 0;
    while ((q.size() != 0 || busy) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", 64'(q.size()), 64'd0);
    check("drain_not_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
